// File: rtl/perceptron_weight_table.sv
// Perceptron weight table: bias plus HIST_LEN history weight columns,
// 2-stage dot-product prediction pipeline, saturating threshold training,
// and a sequenced clear of every entry after reset.
module perceptron_weight_table #(
    parameter int unsigned HIST_LEN  = 32,
    parameter int unsigned ENTRY_NUM = 64,
    parameter int unsigned IDX_W     = $clog2(ENTRY_NUM),
    parameter int unsigned WEIGHT_W  = 8,
    parameter int unsigned THETA     = 75,
    parameter int unsigned SUM_W     = WEIGHT_W + $clog2(HIST_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pred_req,
    output logic                      pred_ready,
    input  logic [IDX_W-1:0]          pred_idx,
    input  logic [HIST_LEN-1:0]       pred_hist,
    output logic                      pred_valid,
    output logic                      pred_taken,
    output logic signed [SUM_W-1:0]   pred_sum,
    input  logic                      upd_valid,
    input  logic [IDX_W-1:0]          upd_idx,
    input  logic [HIST_LEN*IDX_W-1:0] upd_path,
    input  logic [HIST_LEN-1:0]       upd_hist,
    input  logic                      upd_outcome,
    input  logic signed [SUM_W-1:0]   upd_sum,
    output logic                      train_fired
);

    localparam int unsigned COL_NUM = HIST_LEN + 1;
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);
    localparam logic [SUM_W:0]   THETA_EXT = (SUM_W+1)'(THETA);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Control state
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              ready_q, ready_d;

    // Stage 1: registered weights and history
    logic                       s1_valid_q, s1_valid_d;
    logic [HIST_LEN-1:0]        s1_hist_q, s1_hist_d;
    logic signed [WEIGHT_W-1:0] s1_w_q [COL_NUM];
    logic signed [WEIGHT_W-1:0] s1_w_d [COL_NUM];

    // Stage 2: registered result
    logic                     pred_valid_q, pred_valid_d;
    logic                     pred_taken_q, pred_taken_d;
    logic signed [SUM_W-1:0]  pred_sum_q, pred_sum_d;
    logic                     train_fired_q, train_fired_d;

    // Weight storage, one write port per column
    logic signed [WEIGHT_W-1:0] weight_q [COL_NUM][ENTRY_NUM];
    logic                       wr_en_c   [COL_NUM];
    logic [IDX_W-1:0]           wr_addr_c [COL_NUM];
    logic signed [WEIGHT_W-1:0] wr_data_c [COL_NUM];

    logic                     accept_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W:0]    upd_sum_ext_c;
    logic [SUM_W:0]           upd_abs_c;
    logic                     mispredict_c;
    logic                     train_c;

    // One saturating step toward +max (up=1) or -min (up=0)
    function automatic logic signed [WEIGHT_W-1:0] sat_step(
        input logic signed [WEIGHT_W-1:0] w,
        input logic                       up
    );
        logic signed [WEIGHT_W-1:0] r;
        r = w;
        if (up) begin
            if (w != W_MAX) r = w + WEIGHT_W'(1);
        end else begin
            if (w != W_MIN) r = w - WEIGHT_W'(1);
        end
        return r;
    endfunction

    // Sign-extend one weight to the sum width
    function automatic logic signed [SUM_W-1:0] sext(input logic signed [WEIGHT_W-1:0] w);
        return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

    // Init sequencer: clear one index per cycle, then run
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
        ready_d = (state_d == ST_RUN);
    end

    // Training decision; magnitude taken one bit wider so the most negative sum is safe
    always_comb begin
        upd_sum_ext_c = {upd_sum[SUM_W-1], upd_sum};
        upd_abs_c     = upd_sum_ext_c[SUM_W] ? (SUM_W+1)'(-upd_sum_ext_c)
                                             : (SUM_W+1)'(upd_sum_ext_c);
        mispredict_c  = (~upd_sum[SUM_W-1]) != upd_outcome;
        train_c       = upd_valid & ready_q & ~rst & (mispredict_c | (upd_abs_c <= THETA_EXT));
    end

    // Per-column write port: init clear or saturating training step
    always_comb begin
        for (int c = 0; c < COL_NUM; c++) begin
            wr_en_c[c]   = 1'b0;
            wr_addr_c[c] = '0;
            wr_data_c[c] = '0;
        end
        if (!rst && state_q == ST_INIT) begin
            for (int c = 0; c < COL_NUM; c++) begin
                wr_en_c[c]   = 1'b1;
                wr_addr_c[c] = init_cnt_q;
            end
        end else if (train_c) begin
            wr_en_c[0]   = 1'b1;
            wr_addr_c[0] = upd_idx;
            wr_data_c[0] = sat_step(weight_q[0][upd_idx], upd_outcome);
            for (int k = 0; k < HIST_LEN; k++) begin
                wr_en_c[k+1]   = 1'b1;
                wr_addr_c[k+1] = upd_path[k*IDX_W +: IDX_W];
                wr_data_c[k+1] = sat_step(weight_q[k+1][upd_path[k*IDX_W +: IDX_W]],
                                          upd_outcome == upd_hist[k]);
            end
        end
    end

    // Weight array write; reads elsewhere see the pre-edge value
    always_ff @(posedge clk) begin
        for (int c = 0; c < COL_NUM; c++) begin
            if (wr_en_c[c]) begin
                weight_q[c][wr_addr_c[c]] <= wr_data_c[c];
            end
        end
    end

    // Stage 0 -> 1: read all columns at pred_idx on an accepted request
    always_comb begin
        accept_c   = pred_req & ready_q;
        s1_valid_d = accept_c;
        s1_hist_d  = accept_c ? pred_hist : s1_hist_q;
        for (int c = 0; c < COL_NUM; c++) begin
            s1_w_d[c] = accept_c ? weight_q[c][pred_idx] : s1_w_q[c];
        end
    end

    // Stage 1 -> 2: signed dot product and prediction
    always_comb begin
        sum_c = sext(s1_w_q[0]);
        for (int k = 0; k < HIST_LEN; k++) begin
            if (s1_hist_q[k]) sum_c = sum_c + sext(s1_w_q[k+1]);
            else              sum_c = sum_c - sext(s1_w_q[k+1]);
        end
        pred_valid_d  = s1_valid_q;
        pred_sum_d    = s1_valid_q ? sum_c : pred_sum_q;
        pred_taken_d  = s1_valid_q ? ~sum_c[SUM_W-1] : pred_taken_q;
        train_fired_d = train_c;
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            ready_q       <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_hist_q     <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_sum_q    <= '0;
            train_fired_q <= 1'b0;
            for (int c = 0; c < COL_NUM; c++) begin
                s1_w_q[c] <= '0;
            end
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            ready_q       <= ready_d;
            s1_valid_q    <= s1_valid_d;
            s1_hist_q     <= s1_hist_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_sum_q    <= pred_sum_d;
            train_fired_q <= train_fired_d;
            for (int c = 0; c < COL_NUM; c++) begin
                s1_w_q[c] <= s1_w_d[c];
            end
        end
    end

    assign pred_ready  = ready_q;
    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_sum    = pred_sum_q;
    assign train_fired = train_fired_q;

endmodule

// File: tb/tb_perceptron_weight_table.sv
// Directed bench for perceptron_weight_table with hand-computed sums.
module tb_perceptron_weight_table;

    localparam int HL = 32;
    localparam int EN = 64;
    localparam int IW = 6;
    localparam int SW = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pred_req;
    logic                 pred_ready;
    logic [IW-1:0]        pred_idx;
    logic [HL-1:0]        pred_hist;
    logic                 pred_valid;
    logic                 pred_taken;
    logic signed [SW-1:0] pred_sum;
    logic                 upd_valid;
    logic [IW-1:0]        upd_idx;
    logic [HL*IW-1:0]     upd_path;
    logic [HL-1:0]        upd_hist;
    logic                 upd_outcome;
    logic signed [SW-1:0] upd_sum;
    logic                 train_fired;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [HL-1:0] ONES  = {HL{1'b1}};
    localparam logic [HL-1:0] ZEROS = '0;

    perceptron_weight_table dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_ready(pred_ready), .pred_idx(pred_idx),
        .pred_hist(pred_hist), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_sum(pred_sum), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_path(upd_path), .upd_hist(upd_hist), .upd_outcome(upd_outcome),
        .upd_sum(upd_sum), .train_fired(train_fired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HL*IW-1:0] path_all(input logic [IW-1:0] i);
        return {HL{i}};
    endfunction

    task automatic predict_chk(input string tag, input logic [IW-1:0] idx,
                               input logic [HL-1:0] hist, input int exp_sum);
        pred_req = 1'b1; pred_idx = idx; pred_hist = hist;
        tick();
        pred_req = 1'b0;
        tick();
        check({tag, "_vld"}, pred_valid, 1);
        check({tag, "_sum"}, pred_sum, exp_sum);
        check({tag, "_tkn"}, pred_taken, (exp_sum >= 0) ? 1 : 0);
    endtask

    task automatic update(input logic [IW-1:0] idx, input logic [HL*IW-1:0] path,
                          input logic [HL-1:0] hist, input logic outcome,
                          input logic signed [SW-1:0] sum);
        upd_valid = 1'b1; upd_idx = idx; upd_path = path;
        upd_hist = hist; upd_outcome = outcome; upd_sum = sum;
        tick();
        upd_valid = 1'b0;
    endtask

    int n;
    int fires;

    initial begin
        rst = 1'b1; pred_req = 1'b0; pred_idx = '0; pred_hist = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_path = '0; upd_hist = '0;
        upd_outcome = 1'b0; upd_sum = '0;

        // Reset values and init length
        tick();
        tick();
        check("rst_vld", pred_valid, 0);
        check("rst_tf", train_fired, 0);
        check("rst_rdy", pred_ready, 0);
        check("rst_tkn", pred_taken, 0);
        check("rst_sum", pred_sum, 0);
        rst = 1'b0;
        n = 0;
        while (!pred_ready && n < 200) begin
            n++;
            tick();
        end
        check("init_len", n, 64);

        // Every entry clear after init
        for (int i = 0; i < EN; i++) begin
            pred_req = 1'b1; pred_idx = IW'(i); pred_hist = HL'($urandom);
            tick();
            pred_req = 1'b0;
            tick();
            check("clr_sum", pred_sum, 0);
            check("clr_tkn", pred_taken, 1);
        end

        // Bias/history training on entry 7
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            update(6'd7, path_all(6'd7), ONES, 1'b1, 14'sd0);
            fires += int'(train_fired);
        end
        check("bias_fires", fires, 10);
        predict_chk("bias7", 6'd7, ONES, 330);

        // Back-to-back requests with a bubble
        pred_req = 1'b1; pred_idx = 6'd7; pred_hist = ONES;
        tick();
        pred_idx = 6'd7; pred_hist = ZEROS;
        tick();
        pred_idx = 6'd3; pred_hist = ONES;
        check("tp0_vld", pred_valid, 1);
        check("tp0_sum", pred_sum, 330);
        tick();
        pred_req = 1'b0;
        check("tp1_vld", pred_valid, 1);
        check("tp1_sum", pred_sum, -310);
        check("tp1_tkn", pred_taken, 0);
        tick();
        pred_req = 1'b1; pred_idx = 6'd7; pred_hist = ONES;
        check("tp2_vld", pred_valid, 1);
        check("tp2_sum", pred_sum, 0);
        tick();
        pred_req = 1'b0;
        check("tp3_vld", pred_valid, 0);
        check("tp3_hold", pred_sum, 0);
        tick();
        check("tp4_vld", pred_valid, 1);
        check("tp4_sum", pred_sum, 330);
        tick();
        check("tp5_vld", pred_valid, 0);
        check("tp5_hold", pred_sum, 330);
        check("tp5_tkn", pred_taken, 1);

        // Threshold boundaries on entry 20, history all zero
        update(6'd20, path_all(6'd20), ZEROS, 1'b1, 14'sd76);
        check("th_p76", train_fired, 0);
        update(6'd20, path_all(6'd20), ZEROS, 1'b1, 14'sd75);
        check("th_p75", train_fired, 1);
        update(6'd20, path_all(6'd20), ZEROS, 1'b0, 14'sd200);
        check("th_misp", train_fired, 1);
        update(6'd20, path_all(6'd20), ZEROS, 1'b0, -14'sd76);
        check("th_m76", train_fired, 0);
        update(6'd20, path_all(6'd20), ZEROS, 1'b0, -14'sd75);
        check("th_m75", train_fired, 1);
        update(6'd20, path_all(6'd20), ZEROS, 1'b0, -14'sd8192);
        check("th_mneg", train_fired, 0);
        predict_chk("th20_h0", 6'd20, ZEROS, -33);
        predict_chk("th20_h1", 6'd20, ONES, 31);

        // History bit ordering on entry 50
        update(6'd50, path_all(6'd50), 32'h0000_0001, 1'b1, 14'sd0);
        predict_chk("ord_a", 6'd50, 32'h0000_0001, 33);
        predict_chk("ord_b", 6'd50, ZEROS, 31);
        predict_chk("ord_c", 6'd50, 32'h8000_0000, 29);

        // Saturation on entry 30
        for (int i = 0; i < 130; i++) update(6'd30, path_all(6'd30), ONES, 1'b1, 14'sd0);
        predict_chk("sat_hi1", 6'd30, ONES, 4191);
        predict_chk("sat_hi0", 6'd30, ZEROS, -3937);
        for (int i = 0; i < 300; i++) update(6'd30, path_all(6'd30), ONES, 1'b0, 14'sd0);
        predict_chk("sat_lo1", 6'd30, ONES, -4224);
        predict_chk("sat_lo0", 6'd30, ZEROS, 3968);

        // Same-cycle read and write of entry 9
        pred_req = 1'b1; pred_idx = 6'd9; pred_hist = ONES;
        upd_valid = 1'b1; upd_idx = 6'd9; upd_path = path_all(6'd9);
        upd_hist = ONES; upd_outcome = 1'b1; upd_sum = 14'sd0;
        tick();
        upd_valid = 1'b0;
        check("col_tf", train_fired, 1);
        tick();
        pred_req = 1'b0;
        check("col_old_vld", pred_valid, 1);
        check("col_old_sum", pred_sum, 0);
        tick();
        check("col_new_vld", pred_valid, 1);
        check("col_new_sum", pred_sum, 33);

        // Per-column path: column k+1 trained at index k
        for (int k = 0; k < HL; k++) upd_path[k*IW +: IW] = IW'(k);
        update(6'd60, upd_path, ONES, 1'b1, 14'sd0);
        predict_chk("path5_h1", 6'd5, ONES, 1);
        predict_chk("path5_h0", 6'd5, ZEROS, -1);
        predict_chk("path31_h0", 6'd31, ZEROS, -1);
        predict_chk("path60", 6'd60, ONES, 1);

        // Reset with a prediction in flight; traffic during init is dropped
        pred_req = 1'b1; pred_idx = 6'd30; pred_hist = ONES;
        tick();
        pred_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_rdy", pred_ready, 0);
        check("rr_sum", pred_sum, 0);
        n = 0;
        while (!pred_ready && n < 200) begin
            if (n <= 10) check("rr_novld", pred_valid, 0);
            if (n == 4) begin
                upd_valid = 1'b1; upd_idx = 6'd0; upd_path = path_all(6'd0);
                upd_hist = ONES; upd_outcome = 1'b1; upd_sum = 14'sd0;
            end
            if (n == 5) begin
                upd_valid = 1'b0;
                check("rr_tf", train_fired, 0);
            end
            if (n == 6) begin
                pred_req = 1'b1; pred_idx = 6'd7; pred_hist = ONES;
            end
            if (n == 7) pred_req = 1'b0;
            n++;
            tick();
        end
        check("rr_len", n, 64);
        predict_chk("rr_e0", 6'd0, ONES, 0);
        predict_chk("rr_e7", 6'd7, ONES, 0);
        predict_chk("rr_e30", 6'd30, ONES, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_weight_table.md
Name: perceptron_weight_table

Overview:
- Parametrised successor to the path-based perceptron weight array in the branch-predictor fast path.
- Holds one bias weight plus HIST_LEN history weights per entry, each in its own column.
- Computes the perceptron dot product in a 2-stage pipeline and returns a taken/not-taken prediction.
- Trains with saturating weights under the standard threshold rule; clears itself with a sequenced init after reset.

Parameters:
- HIST_LEN, 32, number of history weights (weight columns 1..HIST_LEN; column 0 is the bias).
- ENTRY_NUM, 64, entries per column; power of two.
- IDX_W, $clog2(ENTRY_NUM), entry index width.
- WEIGHT_W, 8, signed two's-complement weight width.
- THETA, 75, training threshold; training also fires on a correct prediction when |sum| <= THETA.
- SUM_W, WEIGHT_W+$clog2(HIST_LEN+1), signed width of the dot-product sum.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pred_req  input  1  prediction request; accepted only when pred_ready=1
- pred_ready  output  1  high when not initialising
- pred_idx  input  IDX_W  entry index read from all columns
- pred_hist  input  HIST_LEN  global history; 1 = taken
- pred_valid  output  1  result valid, 2 cycles after an accepted request
- pred_taken  output  1  prediction; 1 when pred_sum >= 0
- pred_sum  output  SUM_W  signed dot product; the caller returns it at update
- upd_valid  input  1  update request; ignored while initialising
- upd_idx  input  IDX_W  bias (column 0) index
- upd_path  input  HIST_LEN*IDX_W  per-column index; column k+1 uses bits [k*IDX_W +: IDX_W]
- upd_hist  input  HIST_LEN  history used at prediction time
- upd_outcome  input  1  resolved direction; 1 = taken
- upd_sum  input  SUM_W  pred_sum captured at prediction time
- train_fired  output  1  one-cycle pulse, the cycle after an update that trained

Behaviour:
- Reset and init:
  - While rst=1: FSM goes to INIT, init counter = 0, all pipeline valids cleared.
  - Output values during reset: pred_valid=0, train_fired=0, pred_ready=0, pred_taken=0, pred_sum=0.
  - INIT writes 0 to every column at the counter index, one index per cycle, for ENTRY_NUM cycles.
  - INIT then moves to RUN, and pred_ready=1 from that cycle on.
  - rst asserted mid-INIT or mid-RUN restarts INIT from index 0. In-flight predictions are dropped and never produce pred_valid.
- Prediction pipeline (RUN only):
  - Cycle 0 (accept, pred_req & pred_ready): all HIST_LEN+1 columns are read at pred_idx; weights and pred_hist are registered.
  - Cycle 1: sum = w0 + Σk (pred_hist[k] ? +w[k+1] : −w[k+1]), computed sign-extended to SUM_W. No overflow is possible at this width. The sum is registered.
  - Cycle 2: pred_valid=1, pred_sum=sum, pred_taken=(sum>=0).
  - Throughput is 1 request per cycle. pred_valid is deasserted when no request is accepted. pred_taken and pred_sum hold their last values.
- Training (RUN only; decided in the upd_valid cycle, writes land at the clock edge):
  - mispredict = ((upd_sum>=0) != upd_outcome).
  - train = upd_valid & (mispredict | |upd_sum| <= THETA). |upd_sum| is computed in SUM_W+1 bits so the most negative sum is handled.
  - Bias weight at upd_idx: +1 if upd_outcome, else −1.
  - Column k+1 at upd_path[k]: +1 if upd_outcome==upd_hist[k], else −1.
  - Saturation: all updates saturate at +2^(WEIGHT_W−1)−1 and −2^(WEIGHT_W−1); no wrap.
  - Each column has one write port, so all HIST_LEN+1 writes occur in the same cycle.
- Collisions and boundaries:
  - A pipeline read of an entry written by training in the same cycle returns the old (pre-update) value. Read-before-write is required.
  - upd_valid during INIT is dropped and train_fired stays 0.
  - pred_req while pred_ready=0 is ignored.
  - train_fired = registered train. It is independent of the prediction pipeline.

Test Plan:
- Init: pulse rst for 1 cycle → pred_ready low for exactly 64 cycles. Then every entry predicts pred_sum=0, pred_taken=1.
- Latency and throughput: pred_req on idx 3,4,5 in consecutive cycles → pred_valid high on cycles +2,+3,+4 with matching sums. Bubble between requests → pred_valid low in the matching cycle.
- Bias training: 10 updates, upd_idx=7, all upd_path=7, upd_hist=all-ones, outcome=1, upd_sum=0 → train_fired pulses 10 times. Predict idx 7 with hist all-ones → pred_sum = 10+32·10 = 330.
- Threshold: upd_sum=+76, outcome=1 → no train, train_fired=0. upd_sum=+75, outcome=1 → train. upd_sum=+200, outcome=0 → train (mispredict).
- Saturation: 130 taken updates on one entry → bias weight reads 127; 300 not-taken updates → −128. No wrap observed.
- Collision and reset: update entry 9 in the same cycle as a pred_req on 9 → returned sum uses old weights; the next request sees new weights. Assert rst while a prediction is in flight → no pred_valid, and INIT restarts.
